// File: rtl/reg_file_pkg.sv
// Shared register-file geometry and slot record types for reg_file and its
// write arbiter.
package reg_file_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int COUNT_W  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    SLOT0 = 1'b0,
    SLOT1 = 1'b1
  } slot_id_e;

  typedef struct packed {
    logic  full;
    addr_t addr;
    data_t data;
  } slot_t;

  function automatic logic [NUM_REGS-1:0] addr_onehot(input addr_t addr);
    return NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/write_slot.sv
// One-entry write buffer. A push in the same cycle as a pop replaces the
// outgoing entry, so a drained slot can be refilled back-to-back.
module write_slot
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              next_full_o,
  output logic [ADDR_W-1:0] next_addr_o
);

  slot_t slot_q, slot_d;

  always_comb begin
    // NOTE: slot_d takes its default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    slot_d = slot_q;
    if (push_i) begin
      slot_d.full = 1'b1;
      slot_d.addr = push_addr_i;
      slot_d.data = push_data_i;
    end else if (pop_i) begin
      slot_d.full = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignment so every register in
    // the design samples its inputs from the same pre-edge values.
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign ready_o     = !rst && (!slot_q.full || pop_i);
  assign full_o      = slot_q.full;
  assign addr_o      = slot_q.addr;
  assign data_o      = slot_q.data;
  assign next_full_o = slot_d.full;
  assign next_addr_o = slot_d.addr;

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester write arbiter in front of reg_file: one-entry slot per
// requester, round-robin on contention, registered write port.
module reg_write_arbiter
  import reg_file_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [ADDR_W-1:0]   rf_addr1,
  output logic                rf_write_en,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] pending,
  output logic [COUNT_W-1:0]  commit_count
);

  logic              push0, push1, grant0, grant1;
  logic              full0, full1, next_full0, next_full1;
  logic [ADDR_W-1:0] addr0, addr1, next_addr0, next_addr1;
  logic [DATA_W-1:0] data0, data1;

  slot_id_e            ptr_q;
  logic                we_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [COUNT_W-1:0]  count_q;

  assign push0 = req0_valid && req0_ready;
  assign push1 = req1_valid && req1_ready;

  write_slot u_slot0 (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push0),
    .pop_i       (grant0),
    .push_addr_i (req0_addr),
    .push_data_i (req0_data),
    .ready_o     (req0_ready),
    .full_o      (full0),
    .addr_o      (addr0),
    .data_o      (data0),
    .next_full_o (next_full0),
    .next_addr_o (next_addr0)
  );

  write_slot u_slot1 (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push1),
    .pop_i       (grant1),
    .push_addr_i (req1_addr),
    .push_data_i (req1_data),
    .ready_o     (req1_ready),
    .full_o      (full1),
    .addr_o      (addr1),
    .data_o      (data1),
    .next_full_o (next_full1),
    .next_addr_o (next_addr1)
  );

  // The pointer only breaks ties; a lone full slot always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (full0 && full1) begin
        grant0 = (ptr_q == SLOT0);
        grant1 = (ptr_q == SLOT1);
      end else begin
        grant0 = full0;
        grant1 = full1;
      end
    end
  end

  // Pending mirrors the post-edge slot contents, so a same-edge refill or a
  // second slot holding the same register keeps the bit set.
  always_comb begin
    pending_d = '0;
    if (next_full0) pending_d = pending_d | addr_onehot(next_addr0);
    if (next_full1) pending_d = pending_d | addr_onehot(next_addr1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= SLOT0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      we_q      <= grant0 || grant1;
      pending_q <= pending_d;
      if (grant0) begin
        wr_addr_q <= addr0;
        wr_data_q <= data0;
        ptr_q     <= SLOT1;
      end else if (grant1) begin
        wr_addr_q <= addr1;
        wr_data_q <= data1;
        ptr_q     <= SLOT0;
      end
      if (we_q) count_q <= count_q + COUNT_W'(1);
    end
  end

  assign rf_addr1      = we_q ? wr_addr_q : rd_addr;
  assign rf_write_en   = we_q;
  assign rf_write_data = wr_data_q;
  assign pending       = pending_q;
  assign commit_count  = count_q;

endmodule
